// File: rtl/cva6_pkg.sv
// Shared frontend package: RAS sizing limits and the checkpoint record the
// frontend stores once per in-flight branch.
package cva6_pkg;

  // Smallest legal return-address stack depth.
  localparam int unsigned RAS_MIN_DEPTH = 2;

  // Frontend configuration fields the checkpoint record is sized from.
  localparam int unsigned RASDepth = 2;
  localparam int unsigned RASVLEN  = 32;

  localparam int unsigned RAS_PTR_W = (RASDepth > 1) ? $clog2(RASDepth) : 1;
  localparam int unsigned RAS_CNT_W = $clog2(RASDepth + 1);

  // One RAS checkpoint: pointer, occupancy and the top entry at that point.
  typedef struct packed {
    logic [RAS_PTR_W-1:0] ptr;
    logic [RAS_CNT_W-1:0] cnt;
    logic [RASVLEN-1:0]   top;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_chk.sv
// Property checker for ras_ckpt: flags out-of-range restore values and an
// undersized stack configuration. Observes only; drives nothing.
module ras_ckpt_chk
  import cva6_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned PtrW  = 1,
  parameter int unsigned CntW  = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  input logic            restore_i,
  input logic [PtrW-1:0] restore_ptr_i,
  input logic [CntW-1:0] restore_cnt_i
);

  // The stack must hold at least two entries.
  depth_legal_a : assert property (@(posedge clk_i) disable iff (rst_i)
    Depth >= RAS_MIN_DEPTH);

  // A restored pointer must address an existing slot.
  restore_ptr_legal_a : assert property (@(posedge clk_i) disable iff (rst_i)
    restore_i |-> (32'(restore_ptr_i) < Depth));

  // A restored occupancy can never exceed the stack depth.
  restore_cnt_legal_a : assert property (@(posedge clk_i) disable iff (rst_i)
    restore_i |-> (32'(restore_cnt_i) <= Depth));

endmodule

// File: rtl/ras_ckpt.sv
// Circular return-address stack with checkpoint export and single-cycle
// restore. Overflow overwrites the oldest entry; underflowing pops are
// ignored. Depth need not be a power of two, so every pointer step wraps
// explicitly at Depth.
module ras_ckpt
  import cva6_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned VLEN  = 32,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [VLEN-1:0] push_addr_i,
  input  logic            pop_i,
  output logic [VLEN-1:0] top_o,
  output logic            top_valid_o,
  output logic            ovf_o,
  output logic [PtrW-1:0] ckpt_ptr_o,
  output logic [CntW-1:0] ckpt_cnt_o,
  output logic [VLEN-1:0] ckpt_top_o,
  input  logic            restore_i,
  input  logic [PtrW-1:0] restore_ptr_i,
  input  logic [CntW-1:0] restore_cnt_i,
  input  logic [VLEN-1:0] restore_top_i
);

  localparam logic [PtrW-1:0] PTR_MAX = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] CNT_MAX = CntW'(Depth);

  logic [VLEN-1:0] mem_r [Depth];
  logic [PtrW-1:0] tos_r;
  logic [CntW-1:0] cnt_r;

  logic [PtrW-1:0] tos_n_s;
  logic [CntW-1:0] cnt_n_s;
  logic            wr_en_s;
  logic [PtrW-1:0] wr_idx_s;
  logic [VLEN-1:0] wr_data_s;

  // Pointer increment modulo Depth.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PTR_MAX) begin
      return {PtrW{1'b0}};
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  // Pointer decrement modulo Depth.
  function automatic logic [PtrW-1:0] ptr_dec(input logic [PtrW-1:0] p);
    if (p == {PtrW{1'b0}}) begin
      return PTR_MAX;
    end else begin
      return p - PtrW'(1);
    end
  endfunction

  // Next-state selection: flush beats restore beats push/pop.
  always_comb begin
    tos_n_s   = tos_r;
    cnt_n_s   = cnt_r;
    wr_en_s   = 1'b0;
    wr_idx_s  = tos_r;
    wr_data_s = push_addr_i;
    if (flush_i) begin
      // Only occupancy is cleared; stale entries are harmless once invalid.
      cnt_n_s = {CntW{1'b0}};
    end else if (restore_i) begin
      tos_n_s   = restore_ptr_i;
      cnt_n_s   = restore_cnt_i;
      wr_en_s   = 1'b1;
      wr_idx_s  = restore_ptr_i;
      wr_data_s = restore_top_i;
    end else if (push_i && pop_i) begin
      // Return immediately followed by a call: replace the top in place.
      wr_en_s = 1'b1;
      cnt_n_s = (cnt_r == {CntW{1'b0}}) ? CntW'(1) : cnt_r;
    end else if (push_i) begin
      tos_n_s  = ptr_inc(tos_r);
      wr_en_s  = 1'b1;
      wr_idx_s = ptr_inc(tos_r);
      cnt_n_s  = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CntW'(1);
    end else if (pop_i && (cnt_r != {CntW{1'b0}})) begin
      tos_n_s = ptr_dec(tos_r);
      cnt_n_s = cnt_r - CntW'(1);
    end else begin
      // Idle or underflowing pop: state holds.
      wr_en_s = 1'b0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tos_r <= {PtrW{1'b0}};
      cnt_r <= {CntW{1'b0}};
    end else begin
      tos_r <= tos_n_s;
      cnt_r <= cnt_n_s;
    end
  end

  // Entry storage; reset clears every slot so nothing survives a reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_r[i] <= {VLEN{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[wr_idx_s] <= wr_data_s;
    end else begin
      mem_r <= mem_r;
    end
  end

  assign top_o       = mem_r[tos_r];
  assign ckpt_top_o  = mem_r[tos_r];
  assign top_valid_o = (cnt_r != {CntW{1'b0}});
  assign ckpt_ptr_o  = tos_r;
  assign ckpt_cnt_o  = cnt_r;
  // Overflow is flagged only for a push that actually advances a full stack.
  assign ovf_o       = push_i & ~pop_i & ~flush_i & ~restore_i & (cnt_r == CNT_MAX);

  ras_ckpt_chk #(
    .Depth (Depth),
    .PtrW  (PtrW),
    .CntW  (CntW)
  ) u_chk (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .restore_i     (restore_i),
    .restore_ptr_i (restore_ptr_i),
    .restore_cnt_i (restore_cnt_i)
  );

endmodule

// File: tb/tb_ras_ckpt.sv
// Bench for ras_ckpt: directed scenarios on a 2-entry stack, then randomized
// traffic on a 5-entry stack checked against a behavioural model.
module tb_ras_ckpt;

  localparam int D5 = 5;

  logic clk;
  logic rst;

  // Depth-2 instance signals
  logic        f2, pu2, po2, r2, rp2;
  logic [31:0] pa2, rt2;
  logic [1:0]  rc2;
  logic [31:0] t2, ct2;
  logic        v2, ov2, cp2;
  logic [1:0]  cc2;

  // Depth-5 instance signals
  logic        f5, pu5, po5, r5;
  logic [31:0] pa5, rt5;
  logic [2:0]  rp5, rc5;
  logic [31:0] t5, ct5;
  logic        v5, ov5;
  logic [2:0]  cp5, cc5;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the 5-entry stack
  logic [31:0] m_mem [D5];
  int          m_tos;
  int          m_cnt;

  ras_ckpt #(.Depth(2), .VLEN(32)) u_d2 (
    .clk_i(clk), .rst_i(rst), .flush_i(f2), .push_i(pu2), .push_addr_i(pa2),
    .pop_i(po2), .top_o(t2), .top_valid_o(v2), .ovf_o(ov2),
    .ckpt_ptr_o(cp2), .ckpt_cnt_o(cc2), .ckpt_top_o(ct2),
    .restore_i(r2), .restore_ptr_i(rp2), .restore_cnt_i(rc2), .restore_top_i(rt2)
  );

  ras_ckpt #(.Depth(D5), .VLEN(32)) u_d5 (
    .clk_i(clk), .rst_i(rst), .flush_i(f5), .push_i(pu5), .push_addr_i(pa5),
    .pop_i(po5), .top_o(t5), .top_valid_o(v5), .ovf_o(ov5),
    .ckpt_ptr_o(cp5), .ckpt_cnt_o(cc5), .ckpt_top_o(ct5),
    .restore_i(r5), .restore_ptr_i(rp5), .restore_cnt_i(rc5), .restore_top_i(rt5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < D5; i++) m_mem[i] = 32'h0;
    m_tos = 0;
    m_cnt = 0;
  endtask

  // Apply the stack rules to the model for the inputs currently driven.
  task automatic model_update();
    if (f5) begin
      m_cnt = 0;
    end else if (r5) begin
      m_tos = int'(rp5);
      m_cnt = int'(rc5);
      m_mem[m_tos] = rt5;
    end else if (pu5 && po5) begin
      m_mem[m_tos] = pa5;
      if (m_cnt < 1) m_cnt = 1;
    end else if (pu5) begin
      m_tos = (m_tos + 1) % D5;
      m_mem[m_tos] = pa5;
      if (m_cnt < D5) m_cnt = m_cnt + 1;
    end else if (po5 && m_cnt > 0) begin
      m_tos = (m_tos + D5 - 1) % D5;
      m_cnt = m_cnt - 1;
    end
  endtask

  initial begin
    rst = 1'b0;
    f2 = 1'b0; pu2 = 1'b0; po2 = 1'b0; r2 = 1'b0; rp2 = 1'b0; rc2 = 2'd0;
    pa2 = 32'h0; rt2 = 32'h0;
    f5 = 1'b0; pu5 = 1'b0; po5 = 1'b0; r5 = 1'b0; rp5 = 3'd0; rc5 = 3'd0;
    pa5 = 32'h0; rt5 = 32'h0;
    model_reset();

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(v2), 32'd0);
    chk("rst_top", t2, 32'h0);
    chk("rst_cnt", 32'(cc2), 32'd0);
    chk("rst_ovf", 32'(ov2), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic push/pop
    pu2 = 1'b1; pa2 = 32'h8000_0010;
    chk("push1_ovf", 32'(ov2), 32'd0);
    step();
    pa2 = 32'h8000_0020;
    step();
    pu2 = 1'b0;
    #1;
    chk("pp_top2", t2, 32'h8000_0020);
    chk("pp_cnt2", 32'(cc2), 32'd2);
    chk("pp_valid2", 32'(v2), 32'd1);
    po2 = 1'b1;
    step();
    chk("pop1_top", t2, 32'h8000_0010);
    step();
    chk("pop2_valid", 32'(v2), 32'd0);
    chk("pop2_ptr", 32'(cp2), 32'd0);
    step();
    chk("undf_ptr", 32'(cp2), 32'd0);
    chk("undf_cnt", 32'(cc2), 32'd0);
    po2 = 1'b0;

    // Overflow
    pu2 = 1'b1; pa2 = 32'hA;
    chk("ovfA", 32'(ov2), 32'd0);
    step();
    pa2 = 32'hB;
    chk("ovfB", 32'(ov2), 32'd0);
    step();
    pa2 = 32'hC;
    #1;
    chk("ovfC", 32'(ov2), 32'd1);
    step();
    pu2 = 1'b0;
    #1;
    chk("ovf_after", 32'(ov2), 32'd0);
    chk("ovf_topC", t2, 32'hC);
    chk("ovf_cnt", 32'(cc2), 32'd2);
    po2 = 1'b1;
    #1;
    chk("ovf_pop_flag", 32'(ov2), 32'd0);
    step();
    chk("ovf_topB", t2, 32'hB);
    step();
    chk("ovf_lostA", 32'(v2), 32'd0);
    po2 = 1'b0;

    // Checkpoint and restore from a fresh stack
    rst = 1'b1;
    #1 rst = 1'b0;
    pu2 = 1'b1; pa2 = 32'h100;
    step();
    pu2 = 1'b0;
    #1;
    chk("ck_ptr", 32'(cp2), 32'd1);
    chk("ck_cnt", 32'(cc2), 32'd1);
    chk("ck_top", ct2, 32'h100);
    po2 = 1'b1;
    step();
    po2 = 1'b0; pu2 = 1'b1; pa2 = 32'h200;
    step();
    pu2 = 1'b0;
    #1;
    chk("ck_clobber", t2, 32'h200);
    r2 = 1'b1; rp2 = 1'b1; rc2 = 2'd1; rt2 = 32'h100;
    step();
    r2 = 1'b0;
    #1;
    chk("rs_top", t2, 32'h100);
    chk("rs_cnt", 32'(cc2), 32'd1);
    chk("rs_ptr", 32'(cp2), 32'd1);
    po2 = 1'b1;
    step();
    po2 = 1'b0;
    #1;
    chk("rs_pop_valid", 32'(v2), 32'd0);

    // Simultaneous push and pop replaces the top
    pu2 = 1'b1; pa2 = 32'h300;
    step();
    pa2 = 32'h400; po2 = 1'b1;
    #1;
    chk("pp_same_ovf", 32'(ov2), 32'd0);
    step();
    pu2 = 1'b0; po2 = 1'b0;
    #1;
    chk("pp_same_top", t2, 32'h400);
    chk("pp_same_cnt", 32'(cc2), 32'd1);
    chk("pp_same_ptr", 32'(cp2), 32'd1);

    // Restore wins over push
    r2 = 1'b1; rp2 = 1'b0; rc2 = 2'd2; rt2 = 32'h500; pu2 = 1'b1; pa2 = 32'h600;
    #1;
    chk("rs_push_ovf", 32'(ov2), 32'd0);
    step();
    r2 = 1'b0; pu2 = 1'b0;
    #1;
    chk("rs_push_top", t2, 32'h500);
    chk("rs_push_ptr", 32'(cp2), 32'd0);
    chk("rs_push_cnt", 32'(cc2), 32'd2);

    // Flush wins over restore; full-stack push is masked
    f2 = 1'b1; r2 = 1'b1; rp2 = 1'b1; rc2 = 2'd2; rt2 = 32'h700; pu2 = 1'b1; pa2 = 32'h800;
    #1;
    chk("fl_ovf_mask", 32'(ov2), 32'd0);
    step();
    f2 = 1'b0; r2 = 1'b0; pu2 = 1'b0;
    #1;
    chk("fl_cnt", 32'(cc2), 32'd0);
    chk("fl_valid", 32'(v2), 32'd0);
    chk("fl_ptr", 32'(cp2), 32'd0);
    chk("fl_mem_kept", t2, 32'h500);

    // Asynchronous reset mid-sequence
    pu2 = 1'b1; pa2 = 32'h11;
    step();
    pa2 = 32'h22;
    step();
    #1;
    chk("ar_pre_cnt", 32'(cc2), 32'd2);
    chk("ar_pre_top", t2, 32'h22);
    chk("ar_pre_ovf", 32'(ov2), 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_top", t2, 32'h0);
    chk("ar_valid", 32'(v2), 32'd0);
    chk("ar_ptr", 32'(cp2), 32'd0);
    chk("ar_cnt", 32'(cc2), 32'd0);
    chk("ar_ckpt_top", ct2, 32'h0);
    chk("ar_ovf", 32'(ov2), 32'd0);
    #1;
    rst = 1'b0; pu2 = 1'b0;
    model_reset();
    step();

    // Randomized traffic on the 5-entry stack
    for (int i = 0; i < 400; i++) begin
      f5  = ($urandom_range(0, 24) == 0);
      r5  = ($urandom_range(0, 9) == 0);
      rp5 = 3'($urandom_range(0, D5 - 1));
      rc5 = 3'($urandom_range(0, D5));
      rt5 = $urandom;
      pa5 = $urandom;
      if (i < 200) begin
        pu5 = ($urandom_range(0, 9) < 6);
        po5 = ($urandom_range(0, 9) < 3);
      end else begin
        pu5 = ($urandom_range(0, 9) < 3);
        po5 = ($urandom_range(0, 9) < 6);
      end
      #1;
      chk("rnd_top", t5, m_mem[m_tos]);
      chk("rnd_ckpt_top", ct5, m_mem[m_tos]);
      chk("rnd_valid", 32'(v5), 32'(m_cnt != 0));
      chk("rnd_ptr", 32'(cp5), 32'(m_tos));
      chk("rnd_cnt", 32'(cc5), 32'(m_cnt));
      chk("rnd_ovf", 32'(ov5), 32'(pu5 && !po5 && !f5 && !r5 && (m_cnt == D5)));
      model_update();
      step();
    end
    f5 = 1'b0; r5 = 1'b0; pu5 = 1'b0; po5 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
